systolic_mac_pe: RTL and testbench

SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_mac_unit.sv | 73 +++++++
 rtl/systolic_mac_pe.sv | 178 +++++++++++++++++
 tb/tb_systolic_mac_pe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// ============================================================================
// Module  : systolic_pkg
// Purpose : Shared definitions for the systolic MAC processing element:
//           PE state encoding and default operand/accumulator/count widths.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  localparam int c_DATA_W_DEF = 8;
  localparam int c_ACC_W_DEF  = 32;
  localparam int c_CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_mac_unit.sv
// ============================================================================
// Module  : systolic_mac_unit
// Purpose : Purely combinational multiply / extend / accumulate datapath.
//           The product is sign- or zero-extended to ACC_W according to
//           signed_mode_i. The sum either wraps modulo 2^ACC_W or, when the
//           macro SYSTOLIC_SAT_EN is defined, clamps to the ACC_W max/min.
// Ports   : a_i, b_i        - DATA_W operands
//           signed_mode_i   - 1 = two's complement, 0 = unsigned
//           acc_i           - current accumulator value
//           product_o       - extended product a_i*b_i
//           sum_o           - acc_i + product_o (wrapping or saturating)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              signed_mode_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  product_o,
  output logic [ACC_W-1:0]  sum_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;

  // Extending both operands to the full product width and keeping only the
  // low PROD_W bits gives the exact result for signed and unsigned alike.
  always_comb begin
    a_ext = {{DATA_W{signed_mode_i & a_i[DATA_W-1]}}, a_i};
    b_ext = {{DATA_W{signed_mode_i & b_i[DATA_W-1]}}, b_i};
    prod  = a_ext * b_ext;
  end

  generate
    if (ACC_W > PROD_W) begin : g_ext_wide
      assign product_o = {{(ACC_W-PROD_W){signed_mode_i & prod[PROD_W-1]}}, prod};
    end else begin : g_ext_exact
      assign product_o = prod;
    end
  endgenerate

`ifdef SYSTOLIC_SAT_EN
  logic [ACC_W:0] sum_x;

  always_comb begin
    sum_x = {1'b0, acc_i} + {1'b0, product_o};
    sum_o = sum_x[ACC_W-1:0];
    if (signed_mode_i) begin
      // Signed overflow: both addends share a sign that the result lacks.
      if ((acc_i[ACC_W-1] == product_o[ACC_W-1]) &&
          (sum_x[ACC_W-1] != acc_i[ACC_W-1])) begin
        sum_o = acc_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum_x[ACC_W]) begin
      sum_o = '1;
    end
  end
`else
  assign sum_o = acc_i + product_o;
`endif

endmodule

`default_nettype wire

// File: rtl/systolic_mac_pe.sv
// ============================================================================
// Module  : systolic_mac_pe
// Purpose : One processing element of a systolic array. Forwards operands
//           to its neighbours with one cycle of latency, accumulates a
//           k_len-long dot product, and loads the result into a shiftable
//           drain chain. Optional saturation: define SYSTOLIC_SAT_EN.
// Ports   : clk, reset (sync, active low)
//           a_in/b_in/a_valid_in/b_valid_in  - operands and qualifiers
//           a_out/b_out/a_valid_out/b_valid_out - registered forwards
//           signed_mode                      - operand/accumulator signedness
//           start_in, k_len                  - begin dot product, length
//           drain_in/drain_valid_in/shift_en - upstream drain chain
//           drain_out/drain_valid_out        - downstream drain chain
//           busy (in ACCUM), done (one-cycle completion pulse)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int ACC_W  = c_ACC_W_DEF,
  parameter int CNT_W  = c_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              a_valid_in,
  input  logic              b_valid_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              a_valid_out,
  output logic              b_valid_out,
  input  logic              signed_mode,
  input  logic              start_in,
  input  logic [CNT_W-1:0]  k_len,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_valid_in,
  input  logic              shift_en,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_valid_out,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   k_len_q, k_len_d;
  logic [ACC_W-1:0]   drain_q, drain_d;
  logic               drain_valid_q, drain_valid_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  a_q, b_q;
  logic               a_valid_q, b_valid_q;

  logic               fire;
  logic               complete;
  logic [ACC_W-1:0]   product;
  logic [ACC_W-1:0]   sum;

  systolic_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a_i           (a_in),
    .b_i           (b_in),
    .signed_mode_i (signed_mode),
    .acc_i         (acc_q),
    .product_o     (product),
    .sum_o         (sum)
  );

  assign fire = a_valid_in & b_valid_in;

  // Completion is decided on the registered count, so a fire arriving while
  // count already equals k_len_q is ignored and the counter never wraps.
  // A start_in in ACCUM restarts rather than completes.
  assign complete = (state_q == ST_ACCUM) && !start_in && (count_q == k_len_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (start_in) begin
      state_d = ST_ACCUM;
    end else if (complete) begin
      state_d = ST_HOLD;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q == ST_ACCUM);
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    acc_d         = acc_q;
    count_d       = count_q;
    k_len_d       = k_len_q;
    drain_d       = drain_q;
    drain_valid_d = drain_valid_q;
    done_d        = 1'b0;

    if (start_in) begin
      k_len_d = k_len;
      // A zero-length product discards any coincident operand pair.
      if (fire && (k_len != '0)) begin
        acc_d   = product;
        count_d = CNT_W'(1);
      end else begin
        acc_d   = '0;
        count_d = '0;
      end
    end else if ((state_q == ST_ACCUM) && !complete && fire) begin
      acc_d   = sum;
      count_d = count_q + CNT_W'(1);
    end

    // Loading the local result wins over shifting on the completion cycle.
    if (complete) begin
      drain_d       = acc_q;
      drain_valid_d = 1'b1;
      done_d        = 1'b1;
    end else if (shift_en) begin
      drain_d       = drain_in;
      drain_valid_d = drain_valid_in;
    end
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q         <= '0;
      count_q       <= '0;
      k_len_q       <= '0;
      drain_q       <= '0;
      drain_valid_q <= 1'b0;
      done_q        <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      a_valid_q     <= 1'b0;
      b_valid_q     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      count_q       <= count_d;
      k_len_q       <= k_len_d;
      drain_q       <= drain_d;
      drain_valid_q <= drain_valid_d;
      done_q        <= done_d;
      a_q           <= a_in;
      b_q           <= b_in;
      a_valid_q     <= a_valid_in;
      b_valid_q     <= b_valid_in;
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign a_valid_out     = a_valid_q;
  assign b_valid_out     = b_valid_q;
  assign drain_out       = drain_q;
  assign drain_valid_out = drain_valid_q;
  assign done            = done_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_mac_pe.sv
// ============================================================================
// Module  : tb_systolic_mac_pe
// Purpose : Directed self-checking bench for systolic_mac_pe. A 32-bit
//           accumulator instance carries most checks; a 16-bit instance
//           driven by the same stimulus covers wrap/saturation
//           (SYSTOLIC_SAT_EN selects which 16-bit result is expected).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  a_in, b_in;
  logic        a_valid_in, b_valid_in;
  logic        signed_mode, start_in;
  logic [7:0]  k_len;
  logic [31:0] drain_in;
  logic        drain_valid_in, shift_en;

  logic [7:0]  a_out, b_out;
  logic        a_valid_out, b_valid_out;
  logic [31:0] drain_out;
  logic        drain_valid_out, busy, done;

  logic [15:0] drain16_in;
  logic [7:0]  a16_out, b16_out;
  logic        a16_valid_out, b16_valid_out;
  logic [15:0] drain16_out;
  logic        drain16_valid_out, busy16, done16;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(32), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .a_in(a_in), .b_in(b_in), .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
    .a_out(a_out), .b_out(b_out), .a_valid_out(a_valid_out), .b_valid_out(b_valid_out),
    .signed_mode(signed_mode), .start_in(start_in), .k_len(k_len),
    .drain_in(drain_in), .drain_valid_in(drain_valid_in), .shift_en(shift_en),
    .drain_out(drain_out), .drain_valid_out(drain_valid_out),
    .busy(busy), .done(done)
  );

  systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .reset(reset),
    .a_in(a_in), .b_in(b_in), .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
    .a_out(a16_out), .b_out(b16_out), .a_valid_out(a16_valid_out), .b_valid_out(b16_valid_out),
    .signed_mode(signed_mode), .start_in(start_in), .k_len(k_len),
    .drain_in(drain16_in), .drain_valid_in(1'b0), .shift_en(shift_en),
    .drain_out(drain16_out), .drain_valid_out(drain16_valid_out),
    .busy(busy16), .done(done16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ops(input logic [7:0] a, input logic [7:0] b,
                     input logic av, input logic bv);
    a_in       = a;
    b_in       = b;
    a_valid_in = av;
    b_valid_in = bv;
  endtask

  logic [15:0] exp16_sat;

  initial begin
`ifdef SYSTOLIC_SAT_EN
    exp16_sat = 16'hFFFF;
`else
    exp16_sat = 16'hFC02;
`endif
    drain16_in     = 16'h0000;
    // Reset with busy-looking inputs to show reset overrides them.
    reset          = 1'b0;
    signed_mode    = 1'b0;
    start_in       = 1'b1;
    k_len          = 8'd5;
    drain_in       = 32'hDEAD_BEEF;
    drain_valid_in = 1'b1;
    shift_en       = 1'b1;
    ops(8'h55, 8'hAA, 1'b1, 1'b1);
    step();
    step();
    chk("rst_a_out",   a_out, 32'h0);
    chk("rst_a_valid", a_valid_out, 32'h0);
    chk("rst_drain",   drain_out, 32'h0);
    chk("rst_dvalid",  drain_valid_out, 32'h0);
    chk("rst_busy",    busy, 32'h0);
    chk("rst_done",    done, 32'h0);

    // Unsigned k=3: 3*4 + 5*6 + 255*255 = 12 + 30 + 65025 = 65067
    reset          = 1'b1;
    drain_valid_in = 1'b0;
    shift_en       = 1'b0;
    start_in       = 1'b1;
    k_len          = 8'd3;
    ops(8'd3, 8'd4, 1'b1, 1'b1);
    step();
    chk("u3_fwd_a",   a_out, 32'd3);
    chk("u3_fwd_b",   b_out, 32'd4);
    chk("u3_fwd_av",  a_valid_out, 32'd1);
    chk("u3_busy1",   busy, 32'd1);
    start_in = 1'b0;
    ops(8'd5, 8'd6, 1'b1, 1'b1);
    step();
    chk("u3_fwd_a2",  a_out, 32'd5);
    chk("u3_busy2",   busy, 32'd1);
    ops(8'd255, 8'd255, 1'b1, 1'b1);
    step();
    chk("u3_busy3",   busy, 32'd1);
    chk("u3_nodone",  done, 32'd0);
    // A fire arriving once count has reached k_len must not be summed.
    ops(8'd7, 8'd7, 1'b1, 1'b1);
    step();
    chk("u3_busy4",   busy, 32'd0);
    chk("u3_done",    done, 32'd1);
    chk("u3_drain",   drain_out, 32'd65067);
    chk("u3_dvalid",  drain_valid_out, 32'd1);
    ops(8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk("u3_done_pulse", done, 32'd0);
    chk("u3_drain_hold", drain_out, 32'd65067);

    // Signed k=2: -128*127 + (-1)*(-1) = -16256 + 1 = -16255
    signed_mode = 1'b1;
    start_in    = 1'b1;
    k_len       = 8'd2;
    ops(8'h80, 8'h7F, 1'b1, 1'b1);
    step();
    start_in = 1'b0;
    ops(8'hFF, 8'hFF, 1'b1, 1'b1);
    step();
    ops(8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk("s2_done",    done, 32'd1);
    chk("s2_drain",   drain_out, 32'hFFFF_C081);
    chk("s2_drain16", drain16_out, 32'h0000_C081);

    // Unsigned k=2, 255*255 twice = 130050 = 0x1FC02
    signed_mode = 1'b0;
    start_in    = 1'b1;
    k_len       = 8'd2;
    ops(8'd255, 8'd255, 1'b1, 1'b1);
    step();
    start_in = 1'b0;
    step();
    ops(8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk("ovf_done",    done, 32'd1);
    chk("ovf_drain32", drain_out, 32'h0001_FC02);
    chk("ovf_drain16", drain16_out, {16'h0, exp16_sat});

    // Restart mid-ACCUM, with a half-valid cycle that must not count:
    // restart sum = 1*2 + 3*3 = 11
    start_in = 1'b1;
    k_len    = 8'd2;
    ops(8'd10, 8'd10, 1'b1, 1'b1);
    step();
    ops(8'd1, 8'd2, 1'b1, 1'b1);
    step();
    chk("rs_busy", busy, 32'd1);
    start_in = 1'b0;
    ops(8'd99, 8'd99, 1'b1, 1'b0);
    step();
    chk("rs_av_fwd", a_valid_out, 32'd1);
    chk("rs_bv_fwd", b_valid_out, 32'd0);
    chk("rs_busy2",  busy, 32'd1);
    ops(8'd3, 8'd3, 1'b1, 1'b1);
    step();
    ops(8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk("rs_done",  done, 32'd1);
    chk("rs_drain", drain_out, 32'd11);

    // Drain chain: load beats shift on the completion cycle (acc = 2*3 = 6)
    start_in = 1'b1;
    k_len    = 8'd1;
    ops(8'd2, 8'd3, 1'b1, 1'b1);
    step();
    start_in       = 1'b0;
    ops(8'd0, 8'd0, 1'b0, 1'b0);
    drain_in       = 32'h0000_1234;
    drain_valid_in = 1'b1;
    shift_en       = 1'b1;
    step();
    chk("dc_done",   done, 32'd1);
    chk("dc_load",   drain_out, 32'd6);
    chk("dc_lvalid", drain_valid_out, 32'd1);
    step();
    chk("dc_shift",  drain_out, 32'h0000_1234);
    chk("dc_svalid", drain_valid_out, 32'd1);
    shift_en       = 1'b0;
    drain_in       = 32'h0000_ABCD;
    drain_valid_in = 1'b0;
    step();
    chk("dc_hold",   drain_out, 32'h0000_1234);
    shift_en = 1'b1;
    step();
    chk("dc_shift2", drain_out, 32'h0000_ABCD);
    chk("dc_sv0",    drain_valid_out, 32'd0);
    shift_en = 1'b0;

    // Reset after 2 of 4 fires, then zero-length product
    start_in = 1'b1;
    k_len    = 8'd4;
    ops(8'd1, 8'd1, 1'b1, 1'b1);
    step();
    start_in = 1'b0;
    step();
    chk("mr_busy", busy, 32'd1);
    reset = 1'b0;
    step();
    chk("mr_a_out",  a_out, 32'h0);
    chk("mr_bv_out", b_valid_out, 32'h0);
    chk("mr_drain",  drain_out, 32'h0);
    chk("mr_dvalid", drain_valid_out, 32'h0);
    chk("mr_busy0",  busy, 32'h0);
    chk("mr_done",   done, 32'h0);
    chk("mr_state",  u_dut.state_q, 32'h0);
    reset    = 1'b1;
    start_in = 1'b1;
    k_len    = 8'd0;
    ops(8'd9, 8'd9, 1'b1, 1'b1);
    step();
    chk("k0_busy", busy, 32'd1);
    start_in = 1'b0;
    ops(8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk("k0_busy0", busy, 32'd0);
    chk("k0_done",  done, 32'd1);
    chk("k0_drain", drain_out, 32'd0);
    chk("k0_dval",  drain_valid_out, 32'd1);
    chk("k0_state", u_dut.state_q, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
